// File: rtl/frame_packer.sv
// rtl/frame_packer.sv - buffers wide vectors in a FIFO and emits them as framed byte streams.
// Optional trailing XOR checksum byte when FRAME_CHECKSUM_EN is defined.
module frame_packer #(
    parameter int         ELE_WIDTH  = 32,
    parameter int         STAGES     = 4,
    parameter int         FIFO_DEPTH = 2,
    parameter logic [7:0] HDR0       = 8'hAA,
    parameter logic [7:0] HDR1       = 8'h55
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ELE_WIDTH*STAGES-1:0]   vec_in,
    input  logic                          vec_in_vld,
    output logic [7:0]                    byte_out,
    output logic                          byte_vld,
    input  logic                          byte_rdy,
    output logic                          byte_last,
    output logic                          busy,
    output logic                          overflow,
    output logic [15:0]                   drop_cnt
);
    localparam int W  = ELE_WIDTH * STAGES;
    localparam int PB = W / 8;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = (PB > 1) ? $clog2(PB) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_SEQ,
`ifdef FRAME_CHECKSUM_EN
        S_CSUM,
`endif
        S_PAY
    } state_t;

    logic [W-1:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic [15:0]   r_drop_cnt;

    state_t        r_state;
    logic [W-1:0]  r_shift;
    logic [IW-1:0] r_idx;
    logic          r_hdr_sel;
    logic [7:0]    r_seq;
    logic [7:0]    r_byte_out;
    logic          r_byte_vld;
    logic          r_byte_last;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]    r_csum;
`endif

    logic          w_pop;
    logic          w_push;
    logic          w_hs;
    logic [7:0]    w_top;

    assign w_pop  = (r_state == S_IDLE) && (r_count != '0);
    // A full FIFO still accepts a vector when the IDLE pop frees a slot this cycle.
    assign w_push = vec_in_vld && ((r_count < CW'(FIFO_DEPTH)) || w_pop);
    assign w_hs   = r_byte_vld && byte_rdy;
    assign w_top  = r_shift[W-1 -: 8];

    assign byte_out  = r_byte_out;
    assign byte_vld  = r_byte_vld;
    assign byte_last = r_byte_last;
    assign busy      = (r_state != S_IDLE) || (r_count != '0);
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= vec_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= 16'h0000;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
            if (vec_in_vld && !w_push) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 16'hFFFF) begin
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_idx       <= '0;
            r_hdr_sel   <= 1'b0;
            r_seq       <= 8'h00;
            r_byte_out  <= 8'h00;
            r_byte_vld  <= 1'b0;
            r_byte_last <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            r_csum      <= 8'h00;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_byte_vld  <= 1'b0;
                    r_byte_last <= 1'b0;
                    if (w_pop) begin
                        r_shift    <= r_mem[r_rd_ptr];
                        r_byte_out <= HDR0;
                        r_byte_vld <= 1'b1;
                        r_hdr_sel  <= 1'b0;
                        r_state    <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (w_hs) begin
                        if (!r_hdr_sel) begin
                            r_byte_out <= HDR1;
                            r_hdr_sel  <= 1'b1;
                        end else begin
                            r_byte_out <= r_seq;
`ifdef FRAME_CHECKSUM_EN
                            r_csum     <= r_seq;
`endif
                            r_state    <= S_SEQ;
                        end
                    end
                end
                S_SEQ: begin
                    if (w_hs) begin
                        r_byte_out <= w_top;
                        r_shift    <= {r_shift[W-9:0], 8'h00};
                        r_idx      <= '0;
`ifdef FRAME_CHECKSUM_EN
                        r_csum     <= r_csum ^ w_top;
`else
                        r_byte_last <= (PB == 1);
`endif
                        r_state    <= S_PAY;
                    end
                end
                S_PAY: begin
                    if (w_hs) begin
                        if (r_idx < IW'(PB - 1)) begin
                            r_byte_out <= w_top;
                            r_shift    <= {r_shift[W-9:0], 8'h00};
                            r_idx      <= r_idx + IW'(1);
`ifdef FRAME_CHECKSUM_EN
                            r_csum     <= r_csum ^ w_top;
`else
                            r_byte_last <= (r_idx == IW'(PB - 2));
`endif
                        end else begin
`ifdef FRAME_CHECKSUM_EN
                            r_byte_out  <= r_csum;
                            r_byte_last <= 1'b1;
                            r_state     <= S_CSUM;
`else
                            r_byte_vld  <= 1'b0;
                            r_byte_last <= 1'b0;
                            r_seq       <= r_seq + 8'd1;
                            r_state     <= S_IDLE;
`endif
                        end
                    end
                end
`ifdef FRAME_CHECKSUM_EN
                S_CSUM: begin
                    if (w_hs) begin
                        r_byte_vld  <= 1'b0;
                        r_byte_last <= 1'b0;
                        r_seq       <= r_seq + 8'd1;
                        r_state     <= S_IDLE;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_frame_packer.sv
// tb/tb_frame_packer.sv - directed self-checking bench for frame_packer.
module tb_frame_packer;
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] vec_in;
    logic         vec_in_vld;
    logic [7:0]   byte_out;
    logic         byte_vld;
    logic         byte_rdy;
    logic         byte_last;
    logic         busy;
    logic         overflow;
    logic [15:0]  drop_cnt;

    int checks = 0;
    int errors = 0;
    int pc     = 0;
    int waited;

    logic [7:0] exp_b [0:31];
    int         exp_n;

    localparam logic [127:0] V  = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    localparam logic [127:0] VA = 128'hDEADBEEF_01234567_89ABCDEF_F0E1D2C3;
    localparam logic [127:0] VB = 128'h11223344_55667788_99AABBCC_DDEEFF00;
    localparam logic [127:0] VC = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
    localparam logic [127:0] VD = 128'hFFFFFFFF_00000000_12121212_34343434;

    frame_packer dut (
        .clk        (clk),
        .rst        (rst),
        .vec_in     (vec_in),
        .vec_in_vld (vec_in_vld),
        .byte_out   (byte_out),
        .byte_vld   (byte_vld),
        .byte_rdy   (byte_rdy),
        .byte_last  (byte_last),
        .busy       (busy),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build_frame(input logic [127:0] vec, input logic [7:0] sq);
        logic [7:0] cs;
        logic [7:0] b;
        exp_b[0] = 8'hAA;
        exp_b[1] = 8'h55;
        exp_b[2] = sq;
        cs = sq;
        for (int k = 0; k < 16; k++) begin
            b = vec[127 - 8*k -: 8];
            exp_b[3 + k] = b;
            cs = cs ^ b;
        end
`ifdef FRAME_CHECKSUM_EN
        exp_b[19] = cs;
        exp_n = 20;
`else
        exp_n = 19;
`endif
    endtask

    function automatic logic rdy_pat(input int mode);
        logic [3:0] pat;
        pat = 4'b1001;
        if (mode == 0) return 1'b1;
        return pat[3 - (pc % 4)];
    endfunction

    task automatic recv_frame(input logic [127:0] vec, input logic [7:0] sq,
                              input int mode, output int wcnt);
        int stalls;
        build_frame(vec, sq);
        pc = 0;
        wcnt = 0;
        while (!byte_vld && wcnt < 64) begin
            tick;
            wcnt++;
        end
        chk("frame_start_vld", {31'd0, byte_vld}, 32'd1);
        for (int i = 0; i < exp_n; i++) begin
            chk($sformatf("byte%0d", i), {24'd0, byte_out}, {24'd0, exp_b[i]});
            chk($sformatf("last%0d", i), {31'd0, byte_last}, (i == exp_n - 1) ? 32'd1 : 32'd0);
            stalls = 0;
            while (!rdy_pat(mode) && stalls < 8) begin
                pc++;
                stalls++;
                byte_rdy = 1'b0;
                tick;
                chk("stall_data", {24'd0, byte_out}, {24'd0, exp_b[i]});
                chk("stall_vld", {31'd0, byte_vld}, 32'd1);
            end
            pc++;
            byte_rdy = 1'b1;
            tick;
        end
        chk("post_frame_idle", {31'd0, byte_vld}, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        vec_in     = '0;
        vec_in_vld = 1'b0;
        byte_rdy   = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        chk("rst_byte_vld", {31'd0, byte_vld}, 32'd0);
        chk("rst_byte_out", {24'd0, byte_out}, 32'd0);
        chk("rst_byte_last", {31'd0, byte_last}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Single frame and first-byte latency
        vec_in = V;
        vec_in_vld = 1'b1;
        tick;
        vec_in_vld = 1'b0;
        chk("lat_vld_t1", {31'd0, byte_vld}, 32'd0);
        chk("lat_busy_t1", {31'd0, busy}, 32'd1);
        tick;
        chk("lat_vld_t2", {31'd0, byte_vld}, 32'd1);
        chk("lat_hdr0_t2", {24'd0, byte_out}, 32'hAA);
        recv_frame(V, 8'h00, 0, waited);

        // Backpressure 1,0,0,1
        vec_in_vld = 1'b1;
        tick;
        vec_in_vld = 1'b0;
        recv_frame(V, 8'h01, 1, waited);

        // Overflow with sink stalled
        rst = 1'b1;
        tick;
        rst = 1'b0;
        byte_rdy = 1'b0;
        vec_in = VA; vec_in_vld = 1'b1;
        tick;
        vec_in = VB;
        tick;
        vec_in = VC;
        tick;
        vec_in = VD;
        tick;
        vec_in_vld = 1'b0;
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_drop_cnt", {16'd0, drop_cnt}, 32'd1);
        chk("ovf_stall_hdr0", {24'd0, byte_out}, 32'hAA);
        recv_frame(VA, 8'h00, 0, waited);
        recv_frame(VB, 8'h01, 0, waited);
        recv_frame(VC, 8'h02, 0, waited);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("ovf_no_4th_frame", {31'd0, byte_vld}, 32'd0);
        end
        chk("ovf_idle_busy", {31'd0, busy}, 32'd0);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Push in the same cycle as the IDLE pop
        vec_in = VB; vec_in_vld = 1'b1;
        tick;
        vec_in = VC;
        tick;
        vec_in_vld = 1'b0;
        chk("coinc_no_drop", {16'd0, drop_cnt}, 32'd1);
        recv_frame(VB, 8'h03, 0, waited);
        recv_frame(VC, 8'h04, 0, waited);
        chk("coinc_gap", waited, 32'd1);

        // Reset mid-frame with a vector queued
        vec_in = V; vec_in_vld = 1'b1;
        tick;
        vec_in = VD;
        tick;
        vec_in_vld = 1'b0;
        byte_rdy = 1'b1;
        for (int i = 0; i < 8; i++) tick;
        chk("mid_pay5", {24'd0, byte_out}, 32'h05);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mid_rst_vld", {31'd0, byte_vld}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_last", {31'd0, byte_last}, 32'd0);
        chk("mid_rst_drop", {16'd0, drop_cnt}, 32'd0);
        tick;
        chk("mid_rst_stays_idle", {31'd0, byte_vld}, 32'd0);
        vec_in = V; vec_in_vld = 1'b1;
        tick;
        vec_in_vld = 1'b0;
        recv_frame(V, 8'h00, 0, waited);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
